// File: rtl/lcd_timing_gen_if.sv
// Pixel-side bundle of the LCD timing generator: scan request in, position/timing out.
// frame_count exists only when LCD_TIMING_FRAME_COUNT_EN is defined.
interface lcd_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int AW = 22
);
  logic          enable;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] address;
  logic          fetch;
  logic          lcd_hs;
  logic          lcd_vs;
  logic          data_enable;
  logic          line_start;
  logic          frame_start;
  logic          busy;
`ifdef LCD_TIMING_FRAME_COUNT_EN
  logic [15:0]   frame_count;

  modport master (
    input  enable,
    output x, y, address, fetch, lcd_hs, lcd_vs, data_enable,
    output line_start, frame_start, busy, frame_count
  );

  modport slave (
    output enable,
    input  x, y, address, fetch, lcd_hs, lcd_vs, data_enable,
    input  line_start, frame_start, busy, frame_count
  );
`else
  modport master (
    input  enable,
    output x, y, address, fetch, lcd_hs, lcd_vs, data_enable,
    output line_start, frame_start, busy
  );

  modport slave (
    output enable,
    input  x, y, address, fetch, lcd_hs, lcd_vs, data_enable,
    input  line_start, frame_start, busy
  );
`endif
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: h/v scan counters, IDLE/RUN/DRAIN control, delayed sync/DE.
// Optional frame counter output enabled by defining LCD_TIMING_FRAME_COUNT_EN.
module lcd_timing_gen #(
  parameter int H_FRONT  = 24,
  parameter int H_SYNC   = 72,
  parameter int H_BACK   = 96,
  parameter int H_ACT    = 800,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 7,
  parameter int V_ACT    = 480,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int DE_DELAY = 2,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int AW       = 22
) (
  input  logic             clock,
  input  logic             reset_n,
  lcd_timing_gen_if.master bus
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACT;
  localparam int V_TOTAL = V_BLANK + V_ACT;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_BLK  = 12'(H_BLANK);
  localparam logic [11:0] V_BLK  = 12'(V_BLANK);
  localparam logic [11:0] HS_BEG = 12'(H_FRONT);
  localparam logic [11:0] HS_END = 12'(H_FRONT + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_FRONT);
  localparam logic [11:0] VS_END = 12'(V_FRONT + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);
  localparam logic [AW-1:0] H_ACT_A = AW'(H_ACT);

  // Pipeline word: {frame_start, line_start, data_enable, vs level, hs level}
  localparam int PW = 5;
  localparam logic [PW-1:0] PIPE_IDLE = {1'b0, 1'b0, 1'b0, ~VS_ON, ~HS_ON};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        h_wrap, v_wrap, advance;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        advance = 1'b1;
        if (!bus.enable) state_d = DRAIN;
      end
      DRAIN: begin
        advance = 1'b1;
        if (bus.enable)            state_d = RUN;
        else if (h_wrap && v_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters sit at the origin whenever the scanner is not advancing.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (advance) begin
      h_d = h_wrap ? 12'd0 : h_q + 12'd1;
      v_d = v_q;
      if (h_wrap) v_d = v_wrap ? 12'd0 : v_q + 12'd1;
    end
  end

  logic busy, h_act, v_act, in_act, fetch;
  logic hs_on, vs_on, ls_raw, fs_raw;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign busy   = (state_q != IDLE);
  assign h_act  = (h_q >= H_BLK);
  assign v_act  = (v_q >= V_BLK);
  assign in_act = h_act && v_act;
  assign fetch  = in_act && busy;
  assign x      = in_act ? XW'(h_q - H_BLK) : '0;
  assign y      = in_act ? YW'(v_q - V_BLK) : '0;

  assign hs_on  = busy && (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_on  = busy && (v_q >= VS_BEG) && (v_q < VS_END);
  assign ls_raw = busy && (h_q == 12'd0);
  assign fs_raw = ls_raw && (v_q == 12'd0);

  logic [PW-1:0] pipe_d;
  logic [PW-1:0] pipe_q [DE_DELAY+1];

  assign pipe_d = {fs_raw, ls_raw, fetch,
                   vs_on ? VS_ON : ~VS_ON,
                   hs_on ? HS_ON : ~HS_ON};

  // Stage 0 captures the counter-derived word; the last stage drives the panel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= DE_DELAY; i++) pipe_q[i] <= PIPE_IDLE;
    end else begin
      pipe_q[0] <= pipe_d;
      for (int i = 1; i <= DE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.x           = x;
  assign bus.y           = y;
  assign bus.address     = AW'(AW'(y) * H_ACT_A + AW'(x));
  assign bus.fetch       = fetch;
  assign bus.busy        = busy;
  assign bus.lcd_hs      = pipe_q[DE_DELAY][0];
  assign bus.lcd_vs      = pipe_q[DE_DELAY][1];
  assign bus.data_enable = pipe_q[DE_DELAY][2];
  assign bus.line_start  = pipe_q[DE_DELAY][3];
  assign bus.frame_start = pipe_q[DE_DELAY][4];

`ifdef LCD_TIMING_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  logic        fs_next;

  // Count on the same edge that raises frame_start, so the count includes the visible pulse.
  if (DE_DELAY == 0) begin : g_fs_direct
    assign fs_next = fs_raw;
  end else begin : g_fs_piped
    assign fs_next = pipe_q[DE_DELAY-1][4];
  end

  assign fcnt_d = fcnt_q + 16'(fs_next);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  assign bus.frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: a frame-position model predicts every output each cycle.
module tb_lcd_timing_gen;
  localparam int HF = 2, HSW = 3, HB = 2, HA = 8;
  localparam int VF = 1, VSW = 2, VB = 1, VA = 4;
  localparam int DD = 2;
  localparam int HBL = HF + HSW + HB;
  localparam int VBL = VF + VSW + VB;
  localparam int HT  = HBL + HA;
  localparam int VT  = VBL + VA;
  localparam int FT  = HT * VT;

  logic clock;
  logic reset_n;

  lcd_timing_gen_if #(.XW(10), .YW(10), .AW(22)) bus ();

  lcd_timing_gen #(
    .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB), .H_ACT(HA),
    .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .V_ACT(VA),
    .HS_POL(0), .VS_POL(0), .DE_DELAY(DD),
    .XW(10), .YW(10), .AW(22)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        busy;
    logic        fetch;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] addr;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [31:0] fc;
  } exp_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } raw_t;

  exp_t sb_q[$];
  raw_t hist_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_mode;   // 0 idle, 1 scanning on request, 2 finishing the frame
  int   m_p;      // pixel index within the frame, 0..FT-1
  int   m_fc;
  int   rst_hold = 0;
  bit   rst_req  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic raw_t idle_raw();
    raw_t r;
    r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0; r.ls = 1'b0; r.fs = 1'b0;
    return r;
  endfunction

  function automatic exp_t reset_rec();
    exp_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_p    = 0;
    m_fc   = 0;
    hist_q.delete();
    repeat (DD + 1) hist_q.push_back(idle_raw());
  endtask

  // Advance the model across one clock edge given the enable seen at that edge.
  task automatic model_step(input bit en, output exp_t e);
    bit   last;
    int   h, v;
    bit   act;
    raw_t r, d;
    case (m_mode)
      0: if (en) begin m_mode = 1; m_p = 0; end
      1: begin
        m_p = (m_p + 1) % FT;
        if (!en) m_mode = 2;
      end
      default: begin
        last = (m_p == FT - 1);
        m_p  = (m_p + 1) % FT;
        if (en)        m_mode = 1;
        else if (last) m_mode = 0;
      end
    endcase
    if (m_mode == 0) m_p = 0;
    h   = m_p % HT;
    v   = m_p / HT;
    act = (h >= HBL) && (v >= VBL);
    e.busy  = (m_mode != 0);
    e.fetch = act && e.busy;
    e.x     = act ? h - HBL : 0;
    e.y     = act ? v - VBL : 0;
    e.addr  = e.y * HA + e.x;
    r.hs = !(e.busy && h >= HF && h < HF + HSW);
    r.vs = !(e.busy && v >= VF && v < VF + VSW);
    r.de = e.fetch;
    r.ls = e.busy && (h == 0);
    r.fs = r.ls && (v == 0);
    hist_q.push_back(r);
    d = hist_q.pop_front();
    if (d.fs) m_fc = (m_fc + 1) % 65536;
    e.hs = d.hs; e.vs = d.vs; e.de = d.de; e.ls = d.ls; e.fs = d.fs;
    e.fc = m_fc;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (rst_hold > 0) begin
      sb_q.push_back(reset_rec());
      rst_hold--;
      if (rst_hold == 0) reset_n = 1'b1;
    end else begin
      model_step(bus.enable, e);
      if (rst_req && e.hs == 1'b0) begin
        reset_n  = 1'b0;
        rst_req  = 0;
        rst_hold = 3;
        model_reset();
        #1;
        sb_q.push_back(reset_rec());
      end else begin
        sb_q.push_back(e);
      end
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("busy",        32'(bus.busy),        32'(e.busy));
      chk("fetch",       32'(bus.fetch),       32'(e.fetch));
      chk("x",           32'(bus.x),           e.x);
      chk("y",           32'(bus.y),           e.y);
      chk("address",     32'(bus.address),     e.addr);
      chk("lcd_hs",      32'(bus.lcd_hs),      32'(e.hs));
      chk("lcd_vs",      32'(bus.lcd_vs),      32'(e.vs));
      chk("data_enable", 32'(bus.data_enable), 32'(e.de));
      chk("line_start",  32'(bus.line_start),  32'(e.ls));
      chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
`ifdef LCD_TIMING_FRAME_COUNT_EN
      chk("frame_count", 32'(bus.frame_count), e.fc);
`endif
    end
  end

  initial begin
    int n;
    int left;
    int len;
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    #1;
    reset_n = 1'b0;
    model_reset();
    rst_hold = 3;

    // Enable held through reset release, then several full frames.
    repeat (3 + 3 * FT + 20) tick();

    // Drop the request on the first cycle of line 2.
    n = 0;
    while (!(m_mode == 1 && m_p == 2 * HT) && n < 2 * FT) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 2 * FT) begin
      fails++;
      $display("FAIL wait_v2: got timeout after %0d cycles expected line 2 reached", n);
    end
    bus.enable = 1'b0;
    repeat (FT + 40) tick();

    // Restart, drop, then re-raise while still draining.
    bus.enable = 1'b1;
    repeat (130) tick();
    bus.enable = 1'b0;
    repeat (50) tick();
    bus.enable = 1'b1;
    repeat (250) tick();

    // Asynchronous reset while hsync is being driven active.
    rst_req = 1;
    repeat (60) tick();
    tests++;
    if (rst_req) begin
      fails++;
      $display("FAIL midline_reset: got no hsync window expected one within 60 cycles");
      rst_req = 0;
    end

    // Randomised request pattern with occasional resets.
    left = 2000;
    while (left > 0) begin
      len = $urandom_range(1, 260);
      if (len > left) len = left;
      bus.enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) rst_req = 1;
      repeat (len) tick();
      left -= len;
    end

    // Final shutdown: scanner must finish its frame and settle idle.
    rst_req    = 0;
    bus.enable = 1'b0;
    repeat (2 * FT + 20) tick();

    @(negedge clock);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
